// File: rtl/du_uart_tx_arbiter_pkg.sv
// Shared debug-unit definitions: arbiter state encodings and requester indices.
package du_pkg;

  localparam logic [1:0] DU_ARB_IDLE  = 2'd0;
  localparam logic [1:0] DU_ARB_GRANT = 2'd1;
  localparam logic [1:0] DU_ARB_DRAIN = 2'd2;

  localparam int unsigned DU_REQ_MASTER = 0;
  localparam int unsigned DU_REQ_IMEM   = 1;
  localparam int unsigned DU_REQ_REGS   = 2;
  localparam int unsigned DU_REQ_DMEM   = 3;

endpackage

// File: rtl/du_rr_picker.sv
// Combinational round-robin picker: one-hot winner searched from the bit after last_gnt_i.
module du_rr_picker
  import du_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] last_gnt_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             valid_o
);

  logic [N_REQ-1:0] hi_mask;
  logic [N_REQ-1:0] hi_req;
  logic [N_REQ-1:0] pool;

  // Requests strictly above the last winner take precedence; otherwise wrap to bit 0.
  always_comb begin
    hi_mask = ~((last_gnt_i << 1) - N_REQ'(1));
    hi_req  = req_i & hi_mask;
    pool    = (hi_req != '0) ? hi_req : req_i;
    gnt_o   = pool & (~pool + N_REQ'(1));
    valid_o = (req_i != '0);
  end

endmodule

// File: rtl/du_uart_tx_arbiter.sv
// Round-robin owner of the debug unit's UART TX FIFO write port; forwards only the owner's strobes.
module du_uart_tx_arbiter
  import du_pkg::*;
#(
  parameter int unsigned NB_UART_DATA = 8,
  parameter int unsigned N_REQ        = 4
) (
  input  logic                          clk,
  input  logic                          i_rst,
  input  logic [N_REQ-1:0]              i_req,
  input  logic [N_REQ-1:0]              i_wr,
  input  logic [N_REQ*NB_UART_DATA-1:0] i_wdata,
  input  logic [N_REQ-1:0]              i_tx_start,
  input  logic                          i_tx_done,
  output logic [N_REQ-1:0]              o_gnt,
  output logic                          o_wr,
  output logic [NB_UART_DATA-1:0]       o_wdata,
  output logic                          o_tx_start,
  output logic                          o_busy,
  output logic                          o_err
);

  logic [1:0]              state_q, state_d;
  logic [N_REQ-1:0]        gnt_q, gnt_d;
  logic [N_REQ-1:0]        last_q, last_d;
  logic                    wr_q, wr_d;
  logic [NB_UART_DATA-1:0] wdata_q, wdata_d;
  logic                    start_q, start_d;
  logic                    err_q, err_d;
  logic                    pend_q, pend_d;

  logic [N_REQ-1:0]        pick_gnt;
  logic                    pick_valid;
  logic [NB_UART_DATA-1:0] owner_data;
  logic                    fwd_wr, fwd_start, owner_req, intrude;

  du_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req_i      (i_req),
    .last_gnt_i (last_q),
    .gnt_o      (pick_gnt),
    .valid_o    (pick_valid)
  );

  always_comb begin
    owner_data = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (gnt_q[k]) owner_data = i_wdata[k*NB_UART_DATA +: NB_UART_DATA];
    end
    // gnt_q is all-zero in IDLE, so every IDLE strobe lands in intrude.
    fwd_wr    = |(i_wr & gnt_q);
    fwd_start = |(i_tx_start & gnt_q);
    owner_req = |(i_req & gnt_q);
    intrude   = |((i_wr | i_tx_start) & ~gnt_q);

    pend_d  = fwd_start | (pend_q & ~i_tx_done);
    wr_d    = fwd_wr;
    wdata_d = fwd_wr ? owner_data : '0;
    start_d = fwd_start;
    err_d   = err_q | intrude | ((state_q == DU_ARB_DRAIN) & (fwd_wr | fwd_start));

    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    // pend_d includes a start coinciding with the req drop, which must still drain.
    case (state_q)
      DU_ARB_IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_gnt;
          last_d  = pick_gnt;
          state_d = DU_ARB_GRANT;
        end
      end
      DU_ARB_GRANT: begin
        if (!owner_req) begin
          if (pend_d) begin
            state_d = DU_ARB_DRAIN;
          end else begin
            state_d = DU_ARB_IDLE;
            gnt_d   = '0;
          end
        end
      end
      DU_ARB_DRAIN: begin
        if (!pend_d) begin
          state_d = DU_ARB_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = DU_ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= DU_ARB_IDLE;
      gnt_q   <= '0;
      last_q  <= N_REQ'(1) << (N_REQ - 1);
      wr_q    <= 1'b0;
      wdata_q <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      start_q <= start_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

  assign o_gnt      = gnt_q;
  assign o_wr       = wr_q;
  assign o_wdata    = wdata_q;
  assign o_tx_start = start_q;
  assign o_busy     = (state_q != DU_ARB_IDLE);
  assign o_err      = err_q;

endmodule

// File: tb/tb_du_uart_tx_arbiter.sv
// Scoreboard bench for du_uart_tx_arbiter: stimulus pushes expected grants/outputs, a negedge monitor pops them.
module tb_du_uart_tx_arbiter;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  typedef struct packed {
    logic         wr;
    logic [W-1:0] data;
    logic         start;
  } out_t;

  logic           clk = 1'b0;
  logic           i_rst;
  logic [N-1:0]   i_req;
  logic [N-1:0]   i_wr;
  logic [N*W-1:0] i_wdata;
  logic [N-1:0]   i_tx_start;
  logic           i_tx_done;
  logic [N-1:0]   o_gnt;
  logic           o_wr;
  logic [W-1:0]   o_wdata;
  logic           o_tx_start;
  logic           o_busy;
  logic           o_err;

  int checks = 0;
  int errors = 0;
  out_t         exp_out[$];
  logic [N-1:0] exp_gnt[$];
  logic [N-1:0] prev_gnt = '0;

  du_uart_tx_arbiter #(.NB_UART_DATA(W), .N_REQ(N)) dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_req      (i_req),
    .i_wr       (i_wr),
    .i_wdata    (i_wdata),
    .i_tx_start (i_tx_start),
    .i_tx_done  (i_tx_done),
    .o_gnt      (o_gnt),
    .o_wr       (o_wr),
    .o_wdata    (o_wdata),
    .o_tx_start (o_tx_start),
    .o_busy     (o_busy),
    .o_err      (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic wait_gnt(output int idx);
    int n = 0;
    while (o_gnt == '0 && n < 20) begin
      tick();
      n++;
    end
    if (o_gnt == '0) chk("wait_gnt_timeout", 32'd0, 32'd1);
    idx = 0;
    for (int k = 0; k < N; k++) if (o_gnt[k]) idx = k;
  endtask

  task automatic push_out(input logic wr, input logic [W-1:0] data, input logic start);
    out_t e;
    e.wr = wr; e.data = data; e.start = start;
    exp_out.push_back(e);
  endtask

  // Monitor: compares forwarded strobes and new grants against the scoreboard queues.
  always @(negedge clk) begin
    out_t e;
    if (o_wr || o_tx_start) begin
      if (exp_out.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got wr=%0b data=%0h start=%0b expected none at %0t",
                 o_wr, o_wdata, o_tx_start, $time);
      end else begin
        e = exp_out.pop_front();
        chk("out_wr", 32'(o_wr), 32'(e.wr));
        chk("out_wdata", 32'(o_wdata), 32'(e.data));
        chk("out_start", 32'(o_tx_start), 32'(e.start));
      end
    end
    if (o_gnt != prev_gnt && o_gnt != '0) begin
      chk("gnt_gap", 32'(prev_gnt), 32'd0);
      if (exp_gnt.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_gnt: got %0b expected none at %0t", o_gnt, $time);
      end else begin
        chk("gnt_order", 32'(o_gnt), 32'(exp_gnt.pop_front()));
      end
    end
    prev_gnt = o_gnt;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k;
    i_rst = 1'b1; i_req = '0; i_wr = '0; i_wdata = '0; i_tx_start = '0; i_tx_done = 1'b0;
    tick(); tick();
    i_rst = 1'b0;
    chk("rst_gnt", 32'(o_gnt), 32'd0);
    chk("rst_wr", 32'(o_wr), 32'd0);
    chk("rst_start", 32'(o_tx_start), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);

    // Single packet from the regfile sender, two back-to-back bytes.
    exp_gnt.push_back(4'b0100);
    i_req = 4'b0100;
    tick();
    chk("single_gnt", 32'(o_gnt), 32'b0100);
    chk("single_busy", 32'(o_busy), 32'd1);
    i_wr[2] = 1'b1; i_wdata[2*W +: W] = 8'hA5; push_out(1'b1, 8'hA5, 1'b0);
    tick();
    i_wdata[2*W +: W] = 8'h3C; push_out(1'b1, 8'h3C, 1'b0);
    tick();
    i_wr = '0; i_wdata = '0; i_req = '0;
    tick();
    chk("single_release_gnt", 32'(o_gnt), 32'd0);
    chk("single_err", 32'(o_err), 32'd0);
    tick();

    // Contention: all four request, each owner releases after one byte and re-requests.
    do_reset();
    exp_gnt.push_back(4'b0001); exp_gnt.push_back(4'b0010);
    exp_gnt.push_back(4'b0100); exp_gnt.push_back(4'b1000);
    exp_gnt.push_back(4'b0001);
    i_req = 4'b1111;
    for (int it = 0; it < 5; it++) begin
      wait_gnt(k);
      i_wr[k] = 1'b1; i_wdata[k*W +: W] = 8'(8'h10 + k + 16 * it);
      push_out(1'b1, 8'(8'h10 + k + 16 * it), 1'b0);
      tick();
      i_wr = '0; i_wdata = '0; i_req[k] = 1'b0;
      tick();
      chk("cont_idle_gap", 32'(o_gnt), 32'd0);
      if (it < 4) i_req[k] = 1'b1;
      else i_req = '0;
    end
    tick(); tick();

    // Drain: DMEM sender starts a transmission, releases, done arrives 10 cycles later.
    do_reset();
    exp_gnt.push_back(4'b1000);
    i_req = 4'b1000;
    wait_gnt(k);
    i_tx_start[3] = 1'b1; push_out(1'b0, 8'h00, 1'b1);
    tick();
    i_tx_start = '0; i_req = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c == 0 || c == 9) begin
        chk("drain_gnt_held", 32'(o_gnt), 32'b1000);
        chk("drain_busy", 32'(o_busy), 32'd1);
      end
    end
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    chk("drain_release_gnt", 32'(o_gnt), 32'd0);
    chk("drain_release_busy", 32'(o_busy), 32'd0);
    tick();

    // Intruder: IMEM loader owns the bus, regfile sender writes 0xFF.
    do_reset();
    exp_gnt.push_back(4'b0010);
    i_req = 4'b0010;
    wait_gnt(k);
    chk("intr_err_before", 32'(o_err), 32'd0);
    i_wr[2] = 1'b1; i_wdata[2*W +: W] = 8'hFF;
    tick();
    i_wr = '0; i_wdata = '0;
    chk("intr_wr_low", 32'(o_wr), 32'd0);
    chk("intr_err_set", 32'(o_err), 32'd1);
    i_req = '0;
    tick(); tick(); tick();
    chk("intr_err_sticky", 32'(o_err), 32'd1);
    do_reset();
    chk("intr_err_cleared", 32'(o_err), 32'd0);

    // Forwarded start in the same cycle as a stale done keeps the packet pending.
    exp_gnt.push_back(4'b0001);
    i_req = 4'b0001;
    wait_gnt(k);
    i_tx_start[0] = 1'b1; i_tx_done = 1'b1; push_out(1'b0, 8'h00, 1'b1);
    tick();
    i_tx_start = '0; i_tx_done = 1'b0; i_req = '0;
    tick(); tick();
    chk("simul_drain_gnt", 32'(o_gnt), 32'b0001);
    chk("simul_drain_busy", 32'(o_busy), 32'd1);
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    chk("simul_release_gnt", 32'(o_gnt), 32'd0);
    tick();

    // Reset mid-packet while o_wr is active, then full contention restarts at requester 0.
    exp_gnt.push_back(4'b0100);
    i_req = 4'b0100;
    wait_gnt(k);
    i_wr[2] = 1'b1; i_wdata[2*W +: W] = 8'h5A; push_out(1'b1, 8'h5A, 1'b0);
    tick();
    chk("midrst_wr_active", 32'(o_wr), 32'd1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0; i_wr = '0; i_wdata = '0;
    chk("midrst_gnt", 32'(o_gnt), 32'd0);
    chk("midrst_wr", 32'(o_wr), 32'd0);
    chk("midrst_wdata", 32'(o_wdata), 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    exp_gnt.push_back(4'b0001);
    i_req = 4'b1111;
    wait_gnt(k);
    chk("midrst_first_gnt", 32'(o_gnt), 32'b0001);
    i_req = '0;
    tick(); tick(); tick();

    chk("sb_out_empty", 32'(exp_out.size()), 32'd0);
    chk("sb_gnt_empty", 32'(exp_gnt.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
